// File: rtl/fir_pkg.sv
// Shared types and register-index constants for the FIR sequencing controller.
// Opcodes and register numbers match the datapath's encoding.
package fir_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_COPY  = 3'd1,
        OP_LOAD1 = 3'd2,
        OP_LOAD2 = 3'd3,
        OP_ADD   = 3'd4,
        OP_SUB   = 3'd5,
        OP_MUL   = 3'd6
    } op_t;

    typedef enum logic [4:0] {
        S_IDLE,
        S_EIDLE,
        S_LOADC,
        S_STORE,
        S_SH3,
        S_SH2,
        S_SH1,
        S_SH0,
        S_ZERO,
        S_MUL1,
        S_ADD1,
        S_MUL2,
        S_ADD2,
        S_MUL3,
        S_ADD3,
        S_MUL4,
        S_ADD4
    } state_t;

    localparam logic [3:0] R0  = 4'd0;
    localparam logic [3:0] R1  = 4'd1;
    localparam logic [3:0] R2  = 4'd2;
    localparam logic [3:0] R3  = 4'd3;
    localparam logic [3:0] R4  = 4'd4;
    localparam logic [3:0] R5  = 4'd5;
    localparam logic [3:0] R6  = 4'd6;
    localparam logic [3:0] R7  = 4'd7;
    localparam logic [3:0] R8  = 4'd8;
    localparam logic [3:0] R9  = 4'd9;
    localparam logic [3:0] R10 = 4'd10;

    function automatic logic [3:0] coef_reg(input logic [1:0] n);
        return R6 + {2'b00, n};
    endfunction

endpackage

// File: rtl/fir_controller.sv
// Moore sequencer driving a 4-tap FIR datapath: coefficient loads,
// sample shift, and multiply-accumulate with overflow trap.
module fir_controller
    import fir_pkg::*;
(
    input  logic       clk,
    input  logic       n_reset,
    input  logic       data_ready,
    input  logic       load_coeff,
    input  logic [1:0] coefficient_num,
    input  logic       overflow,
    output logic       modwait,
    output logic       err,
    output logic [2:0] op,
    output logic [3:0] src1,
    output logic [3:0] src2,
    output logic [3:0] dest,
    output logic       cnt_up
);

    state_t     state_q, state_d;
    logic [1:0] coef_q, coef_d;
    op_t        op_c;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            coef_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            coef_q  <= coef_d;
        end
    end

    // Coefficient index is latched on acceptance so LOADC stays Moore.
    always_comb begin
        state_d = state_q;
        coef_d  = coef_q;
        case (state_q)
            S_IDLE, S_EIDLE: begin
                if (load_coeff) begin
                    state_d = S_LOADC;
                    coef_d  = coefficient_num;
                end else if (data_ready) begin
                    state_d = S_STORE;
                end
            end
            S_LOADC: state_d = S_IDLE;
            S_STORE: state_d = data_ready ? S_SH3 : S_IDLE;
            S_SH3:   state_d = S_SH2;
            S_SH2:   state_d = S_SH1;
            S_SH1:   state_d = S_SH0;
            S_SH0:   state_d = S_ZERO;
            S_ZERO:  state_d = S_MUL1;
            S_MUL1:  state_d = S_ADD1;
            S_ADD1:  state_d = overflow ? S_EIDLE : S_MUL2;
            S_MUL2:  state_d = S_ADD2;
            S_ADD2:  state_d = overflow ? S_EIDLE : S_MUL3;
            S_MUL3:  state_d = S_ADD3;
            S_ADD3:  state_d = overflow ? S_EIDLE : S_MUL4;
            S_MUL4:  state_d = S_ADD4;
            S_ADD4:  state_d = overflow ? S_EIDLE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        modwait = 1'b1;
        err     = 1'b0;
        op_c    = OP_NOP;
        src1    = R0;
        src2    = R0;
        dest    = R0;
        cnt_up  = 1'b0;
        case (state_q)
            S_IDLE:  modwait = 1'b0;
            S_EIDLE: begin
                modwait = 1'b0;
                err     = 1'b1;
            end
            S_LOADC: begin
                op_c = OP_LOAD2;
                dest = coef_reg(coef_q);
            end
            S_STORE: begin
                op_c   = OP_LOAD1;
                dest   = R5;
                cnt_up = 1'b1;
            end
            S_SH3: begin
                op_c = OP_COPY;
                src1 = R3;
                dest = R4;
            end
            S_SH2: begin
                op_c = OP_COPY;
                src1 = R2;
                dest = R3;
            end
            S_SH1: begin
                op_c = OP_COPY;
                src1 = R1;
                dest = R2;
            end
            S_SH0: begin
                op_c = OP_COPY;
                src1 = R5;
                dest = R1;
            end
            S_ZERO: op_c = OP_SUB;
            S_MUL1: begin
                op_c = OP_MUL;
                src1 = R1;
                src2 = R6;
                dest = R10;
            end
            S_MUL2: begin
                op_c = OP_MUL;
                src1 = R2;
                src2 = R7;
                dest = R10;
            end
            S_MUL3: begin
                op_c = OP_MUL;
                src1 = R3;
                src2 = R8;
                dest = R10;
            end
            S_MUL4: begin
                op_c = OP_MUL;
                src1 = R4;
                src2 = R9;
                dest = R10;
            end
            S_ADD1, S_ADD2, S_ADD3, S_ADD4: begin
                op_c = OP_ADD;
                src2 = R10;
            end
            default: modwait = 1'b0;
        endcase
    end

    assign op = op_c;

endmodule

// File: tb/tb_fir_controller.sv
// Scoreboard bench for fir_controller: stimulus queues expected outputs,
// a negedge monitor pops and compares.
module tb_fir_controller;

    logic       clk;
    logic       n_reset;
    logic       data_ready;
    logic       load_coeff;
    logic [1:0] coefficient_num;
    logic       overflow;
    logic       modwait;
    logic       err;
    logic [2:0] op;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dest;
    logic       cnt_up;

    int checks = 0;
    int failures = 0;

    logic [17:0] exp_q[$];
    string       nm_q[$];
    logic [17:0] seq[14];
    logic [17:0] zv;
    logic [17:0] ev;

    fir_controller dut (
        .clk(clk),
        .n_reset(n_reset),
        .data_ready(data_ready),
        .load_coeff(load_coeff),
        .coefficient_num(coefficient_num),
        .overflow(overflow),
        .modwait(modwait),
        .err(err),
        .op(op),
        .src1(src1),
        .src2(src2),
        .dest(dest),
        .cnt_up(cnt_up)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [17:0] mk(input logic mw, input logic er,
                                       input logic [2:0] o,
                                       input logic [3:0] s1,
                                       input logic [3:0] s2,
                                       input logic [3:0] d,
                                       input logic cu);
        return {mw, er, o, s1, s2, d, cu};
    endfunction

    always @(negedge clk) begin
        logic [17:0] e;
        logic [17:0] g;
        string       n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            g = {modwait, err, op, src1, src2, dest, cnt_up};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL %s got mw=%b err=%b op=%0d s1=%0d s2=%0d d=%0d cu=%b exp mw=%b err=%b op=%0d s1=%0d s2=%0d d=%0d cu=%b",
                         n, g[17], g[16], g[15:13], g[12:9], g[8:5], g[4:1], g[0],
                         e[17], e[16], e[15:13], e[12:9], e[8:5], e[4:1], e[0]);
            end
        end
    end

    task automatic cyc(input logic dr, input logic lc,
                       input logic [1:0] cn, input logic ov,
                       input logic [17:0] e, input string nm);
        @(posedge clk);
        #1;
        data_ready      = dr;
        load_coeff      = lc;
        coefficient_num = cn;
        overflow        = ov;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    initial begin
        zv = mk(0, 0, 0, 0, 0, 0, 0);
        ev = mk(0, 1, 0, 0, 0, 0, 0);
        seq[0]  = mk(1, 0, 2, 0, 0, 5, 1);
        seq[1]  = mk(1, 0, 1, 3, 0, 4, 0);
        seq[2]  = mk(1, 0, 1, 2, 0, 3, 0);
        seq[3]  = mk(1, 0, 1, 1, 0, 2, 0);
        seq[4]  = mk(1, 0, 1, 5, 0, 1, 0);
        seq[5]  = mk(1, 0, 5, 0, 0, 0, 0);
        seq[6]  = mk(1, 0, 6, 1, 6, 10, 0);
        seq[7]  = mk(1, 0, 4, 0, 10, 0, 0);
        seq[8]  = mk(1, 0, 6, 2, 7, 10, 0);
        seq[9]  = mk(1, 0, 4, 0, 10, 0, 0);
        seq[10] = mk(1, 0, 6, 3, 8, 10, 0);
        seq[11] = mk(1, 0, 4, 0, 10, 0, 0);
        seq[12] = mk(1, 0, 6, 4, 9, 10, 0);
        seq[13] = mk(1, 0, 4, 0, 10, 0, 0);

        n_reset = 1'b0;
        data_ready = 1'b0;
        load_coeff = 1'b0;
        coefficient_num = 2'd0;
        overflow = 1'b0;
        repeat (2) @(posedge clk);
        cyc(0, 0, 0, 0, zv, "reset");
        n_reset = 1'b1;
        cyc(0, 0, 0, 0, zv, "idle_hold");

        // single coefficient load, index changes under LOADC
        cyc(0, 1, 2, 0, zv, "idle_lc");
        cyc(0, 0, 0, 0, mk(1, 0, 3, 0, 0, 8, 0), "loadc_f2");
        cyc(0, 0, 0, 0, zv, "loadc_ret");

        // full sample run; requests and stray overflow ignored while busy
        cyc(1, 0, 0, 0, zv, "idle_full");
        for (int i = 0; i < 14; i++) begin
            logic is_add;
            is_add = (i >= 7) && (i % 2 == 1);
            cyc((i == 13) ? 1'b0 : 1'b1, (i >= 1 && i <= 4), 2'd3, !is_add,
                seq[i], $sformatf("full%0d", i));
        end
        cyc(0, 0, 0, 0, zv, "full_end");

        // overflow trap in ADD2
        cyc(1, 0, 0, 0, zv, "idle_ov");
        for (int i = 0; i < 10; i++)
            cyc(i == 0, 0, 0, i == 9, seq[i], $sformatf("ov%0d", i));
        cyc(0, 0, 0, 0, ev, "eidle");
        cyc(1, 0, 0, 0, ev, "eidle_req");
        cyc(0, 0, 0, 0, seq[0], "store_clr");
        cyc(0, 0, 0, 0, zv, "abort_idle");
        cyc(0, 0, 0, 0, zv, "abort_idle2");

        // simultaneous requests: coefficient first, then sample
        cyc(1, 1, 1, 0, zv, "idle_both");
        cyc(1, 0, 0, 0, mk(1, 0, 3, 0, 0, 7, 0), "loadc_f1");
        cyc(1, 0, 0, 0, zv, "both_idle");
        cyc(0, 0, 0, 0, seq[0], "both_store");
        cyc(0, 0, 0, 0, zv, "both_abort");

        // short asynchronous reset pulse mid-MUL2
        cyc(1, 0, 0, 0, zv, "idle_rst");
        for (int i = 0; i < 9; i++)
            cyc(1, 0, 0, 0, seq[i], $sformatf("rst%0d", i));
        @(negedge clk);
        #1 n_reset = 1'b0;
        #2 n_reset = 1'b1;
        data_ready = 1'b0;
        cyc(0, 0, 0, 0, zv, "rst_mid");
        cyc(0, 0, 0, 0, zv, "rst_idle");

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
